// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: opcodes, FSM states, access sizes
// and small opcode-classification helpers.
package lsu_pkg;

    typedef enum logic [2:0] {
        LSU_LW  = 3'd0,
        LSU_LH  = 3'd1,
        LSU_LHU = 3'd2,
        LSU_LB  = 3'd3,
        LSU_LBU = 3'd4,
        LSU_SW  = 3'd5,
        LSU_SH  = 3'd6,
        LSU_SB  = 3'd7
    } lsu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    function automatic lsu_size_e op_size(input lsu_op_e op);
        case (op)
            LSU_LB, LSU_LBU, LSU_SB: return SZ_BYTE;
            LSU_LH, LSU_LHU, LSU_SH: return SZ_HALF;
            default:                 return SZ_WORD;
        endcase
    endfunction

    function automatic logic op_is_load(input lsu_op_e op);
        return (op == LSU_LW) || (op == LSU_LH) || (op == LSU_LHU) ||
               (op == LSU_LB) || (op == LSU_LBU);
    endfunction

    function automatic logic op_sign_ext(input lsu_op_e op);
        return (op == LSU_LB) || (op == LSU_LH);
    endfunction

    // Word accesses need a 4-byte boundary, halfword accesses a 2-byte boundary.
    function automatic logic op_misaligned(input lsu_op_e op, input logic [1:0] offset);
        case (op_size(op))
            SZ_WORD: return offset != 2'b00;
            SZ_HALF: return offset[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane steering: extracts and extends a load from a memory
// word, and merges sub-word store data into a previously read word.
module lsu_byte_lane
    import lsu_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [31:0] ext_word,
    input  logic [31:0] base_word,
    input  logic [31:0] store_data,
    input  logic [1:0]  offset,
    input  lsu_size_e   size,
    input  logic        sign_ext,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [4:0]  shift;
    logic [31:0] lane_mask;
    logic [31:0] shifted;

    // Lane position as a bit shift; big-endian counts lanes from the MSB end.
    always_comb begin
        shift     = 5'd0;
        lane_mask = 32'hFFFF_FFFF;
        case (size)
            SZ_BYTE: begin
                lane_mask = 32'h0000_00FF;
                shift     = BIG_ENDIAN ? {~offset, 3'b000} : {offset, 3'b000};
            end
            SZ_HALF: begin
                lane_mask = 32'h0000_FFFF;
                shift     = BIG_ENDIAN ? {~offset[1], 4'b0000} : {offset[1], 4'b0000};
            end
            default: ;
        endcase
    end

    assign shifted = ext_word >> shift;

    always_comb begin
        load_data = ext_word;
        case (size)
            SZ_BYTE: load_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

    assign merge_data = (base_word & ~(lane_mask << shift)) |
                        ((store_data & lane_mask) << shift);

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: sequences loads, word stores and read-modify-write
// sub-word stores, stalling the pipeline until each access completes.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS  = 32,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Req,
    input  logic [2:0]  Op,
    input  logic [31:0] Addr,
    input  logic [31:0] StoreData,
    output logic        Stall,
    output logic        Done,
    output logic [31:0] LoadData,
    output logic        AlignErr,
    output logic [31:0] MemAddress,
    output logic [31:0] MemWriteData,
    input  logic [31:0] MemReadData,
    output logic        MemWriteEn,
    output logic        MemReadEn
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    lsu_state_e         state_q, state_d;
    lsu_op_e            op_q;
    logic [IDX_W+1:0]   addr_q;
    logic [31:0]        sdata_q;
    logic [31:0]        rdword_q;
    logic [31:0]        load_q;
    logic               align_q;

    lsu_op_e            op_in;
    logic               misaligned_in;
    logic [31:0]        lane_load;
    logic [31:0]        lane_merge;
    logic               unused_addr;

    assign op_in         = lsu_op_e'(Op);
    assign misaligned_in = op_misaligned(op_in, Addr[1:0]);
    // Upper address bits wrap modulo MEM_WORDS and are deliberately ignored.
    assign unused_addr   = ^Addr[31:IDX_W+2];

    lsu_byte_lane #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_lane (
        .ext_word   (MemReadData),
        .base_word  (rdword_q),
        .store_data (sdata_q),
        .offset     (addr_q[1:0]),
        .size       (op_size(op_q)),
        .sign_ext   (op_sign_ext(op_q)),
        .load_data  (lane_load),
        .merge_data (lane_merge)
    );

    always_ff @(posedge Clock) begin
        if (Reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (Req) begin
                    if (misaligned_in)       state_d = ST_RESP;
                    else if (op_in == LSU_SW) state_d = ST_WR;
                    else                      state_d = ST_RD;
                end
            end
            ST_RD:   state_d = op_is_load(op_q) ? ST_RESP : ST_WR;
            ST_WR:   state_d = ST_RESP;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request is latched on accept so Op/Addr may change once Stall drops.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            op_q     <= LSU_LW;
            addr_q   <= '0;
            sdata_q  <= '0;
            rdword_q <= '0;
            load_q   <= '0;
            align_q  <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && Req) begin
                op_q    <= op_in;
                addr_q  <= Addr[IDX_W+1:0];
                sdata_q <= StoreData;
                align_q <= misaligned_in;
            end
            if (state_q == ST_RD) begin
                rdword_q <= MemReadData;
                if (op_is_load(op_q)) load_q <= lane_load;
            end
        end
    end

    assign Stall        = ((state_q == ST_IDLE) && Req) || (state_q == ST_RD) || (state_q == ST_WR);
    assign Done         = (state_q == ST_RESP);
    assign AlignErr     = (state_q == ST_RESP) && align_q;
    assign MemReadEn    = (state_q == ST_RD);
    // Gating with Reset keeps a write that is being aborted from reaching memory.
    assign MemWriteEn   = (state_q == ST_WR) && !Reset;
    assign MemAddress   = {{(32-IDX_W){1'b0}}, addr_q[IDX_W+1:2]};
    assign MemWriteData = (state_q == ST_WR) ? ((op_q == LSU_SW) ? sdata_q : lane_merge) : 32'h0;
    assign LoadData     = load_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: word-addressed memory with negedge write and
// combinational read, plus a byte-array reference model of every access.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int MEM_WORDS  = 32;
    localparam bit BIG_ENDIAN = 1'b1;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Req = 1'b0;
    logic [2:0]  Op = 3'd0;
    logic [31:0] Addr = 32'h0;
    logic [31:0] StoreData = 32'h0;
    logic        Stall, Done, AlignErr, MemWriteEn, MemReadEn;
    logic [31:0] LoadData, MemAddress, MemWriteData, MemReadData;

    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    logic [31:0] last_load = 32'h0;

    int checks = 0;
    int errors = 0;

    logic [31:0] got_load;
    logic        got_align;
    int          got_lat;

    load_store_unit #(.MEM_WORDS(MEM_WORDS), .BIG_ENDIAN(BIG_ENDIAN)) dut (
        .Clock(Clock), .Reset(Reset), .Req(Req), .Op(Op), .Addr(Addr),
        .StoreData(StoreData), .Stall(Stall), .Done(Done), .LoadData(LoadData),
        .AlignErr(AlignErr), .MemAddress(MemAddress), .MemWriteData(MemWriteData),
        .MemReadData(MemReadData), .MemWriteEn(MemWriteEn), .MemReadEn(MemReadEn)
    );

    always #5 Clock = ~Clock;

    always @(negedge Clock) if (MemWriteEn) mem[MemAddress[4:0]] <= MemWriteData;
    assign MemReadData = mem[MemAddress[4:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Byte k of a word in memory order under the configured endianness.
    function automatic logic [7:0] get_byte(input logic [31:0] w, input int k);
        int pos;
        pos = BIG_ENDIAN ? 3 - k : k;
        return w[8*pos +: 8];
    endfunction

    function automatic logic [31:0] set_byte(input logic [31:0] w, input int k, input logic [7:0] b);
        logic [31:0] r;
        int pos;
        r = w;
        pos = BIG_ENDIAN ? 3 - k : k;
        r[8*pos +: 8] = b;
        return r;
    endfunction

    task automatic poke(input int idx, input logic [31:0] val);
        mem[idx] <= val;
        ref_mem[idx] = val;
        #1;
    endtask

    // Issue one request from IDLE (called at posedge+1) and check it through to Done.
    task automatic run_op(input lsu_op_e op, input logic [31:0] addr, input logic [31:0] sd);
        int idx, off, lat, nrd, nwr, cyc;
        logic mis, is_load, is_store;
        logic [31:0] old, new_w, exp_load;
        logic [15:0] half;
        logic [7:0] b;
        bit finished;
        idx = int'((addr / 4) % MEM_WORDS);
        off = int'(addr % 4);
        is_load  = (op == LSU_LW || op == LSU_LH || op == LSU_LHU || op == LSU_LB || op == LSU_LBU);
        is_store = !is_load;
        mis = (op == LSU_LW && off != 0) ||
              ((op == LSU_LH || op == LSU_LHU || op == LSU_SH) && (off % 2) != 0);
        old = ref_mem[idx];
        new_w = old;
        exp_load = old;
        half = BIG_ENDIAN ? {get_byte(old, off), get_byte(old, (off + 1) % 4)}
                          : {get_byte(old, (off + 1) % 4), get_byte(old, off)};
        b = get_byte(old, off);
        case (op)
            LSU_LB:  exp_load = {{24{b[7]}}, b};
            LSU_LBU: exp_load = {24'h0, b};
            LSU_LH:  exp_load = {{16{half[15]}}, half};
            LSU_LHU: exp_load = {16'h0, half};
            LSU_SW:  new_w = sd;
            LSU_SB:  new_w = set_byte(old, off, sd[7:0]);
            LSU_SH:  begin
                if (BIG_ENDIAN) new_w = set_byte(set_byte(old, off, sd[15:8]), (off + 1) % 4, sd[7:0]);
                else            new_w = set_byte(set_byte(old, off, sd[7:0]), (off + 1) % 4, sd[15:8]);
            end
            default: ;
        endcase
        if (mis)                          lat = 1;
        else if (op == LSU_SB || op == LSU_SH) lat = 3;
        else                              lat = 2;
        if (!mis && is_store) ref_mem[idx] = new_w;
        if (!mis && is_load)  last_load = exp_load;

        Req = 1'b1; Op = op; Addr = addr; StoreData = sd;
        #1;
        check("stall_on_req", {31'h0, Stall}, 32'h1);
        nrd = 0; nwr = 0; finished = 0;
        for (cyc = 1; cyc <= 10; cyc++) begin
            @(posedge Clock); #1;
            check("rd_wr_exclusive", {31'h0, MemReadEn & MemWriteEn}, 32'h0);
            if (MemReadEn) begin
                nrd++;
                check("rd_addr", MemAddress, idx);
            end
            if (MemWriteEn) begin
                nwr++;
                check("wr_addr", MemAddress, idx);
                check("wr_data", MemWriteData, new_w);
            end
            if (Done) begin
                finished = 1;
                break;
            end
            check("stall_busy", {31'h0, Stall}, 32'h1);
        end
        if (!finished) check("done_timeout", 32'h0, 32'h1);
        got_lat = cyc; got_load = LoadData; got_align = AlignErr;
        check("latency", cyc, lat);
        check("align_err", {31'h0, AlignErr}, {31'h0, mis});
        check("stall_resp", {31'h0, Stall}, 32'h0);
        check("load_data", LoadData, last_load);
        check("read_pulses", nrd, (!mis && (is_load || op != LSU_SW)) ? 1 : 0);
        check("write_pulses", nwr, (!mis && is_store) ? 1 : 0);
        check("mem_word", mem[idx], ref_mem[idx]);
        Req = 1'b0;
        @(posedge Clock); #1;
        check("idle_after", {30'h0, Done, Stall}, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i] <= $urandom;
        end
        #1;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = mem[i];
        repeat (3) @(posedge Clock);
        #1;
        Reset = 1'b0;
        #1;
        check("rst_outputs", {27'h0, Stall, Done, AlignErr, MemReadEn, MemWriteEn}, 32'h0);
        check("rst_loaddata", LoadData, 32'h0);
        check("rst_memaddr", MemAddress, 32'h0);
        check("rst_wdata", MemWriteData, 32'h0);
        @(posedge Clock); #1;

        // Literal scenarios pinning the model.
        poke(2, 32'hDEADBEEF);
        run_op(LSU_LW, 32'h08, 32'h0);
        check("t1_lw", got_load, 32'hDEADBEEF);
        poke(2, 32'h1280FF00);
        run_op(LSU_LB, 32'h09, 32'h0);
        check("t2_lb", got_load, 32'hFFFFFF80);
        run_op(LSU_LBU, 32'h09, 32'h0);
        check("t2_lbu", got_load, 32'h00000080);
        run_op(LSU_LHU, 32'h0A, 32'h0);
        check("t2_lhu", got_load, 32'h0000FF00);
        poke(3, 32'h11223344);
        run_op(LSU_SB, 32'h0E, 32'h000000AB);
        check("t3_sb", mem[3], 32'h1122AB44);
        check("t3_lat", got_lat, 3);
        run_op(LSU_SH, 32'h05, 32'h1234);
        check("t4_align", {31'h0, got_align}, 32'h1);
        check("t4_lat", got_lat, 1);

        // Reset during the write cycle of a word store.
        poke(4, 32'h0BADF00D);
        Req = 1'b1; Op = LSU_SW; Addr = 32'h10; StoreData = 32'h55555555;
        @(posedge Clock); #1;
        check("t5_in_wr", {31'h0, MemWriteEn}, 32'h1);
        Reset = 1'b1; Req = 1'b0;
        #1;
        check("t5_we_gated", {31'h0, MemWriteEn}, 32'h0);
        @(posedge Clock); #1;
        check("t5_outputs", {27'h0, Stall, Done, AlignErr, MemReadEn, MemWriteEn}, 32'h0);
        check("t5_loaddata", LoadData, 32'h0);
        check("t5_memaddr", MemAddress, 32'h0);
        check("t5_mem4", mem[4], 32'h0BADF00D);
        last_load = 32'h0;
        Reset = 1'b0;
        @(posedge Clock); #1;

        // Simultaneous Req and Reset: request dropped.
        Req = 1'b1; Reset = 1'b1; Op = LSU_LW; Addr = 32'h0;
        @(posedge Clock); #1;
        Req = 1'b0; Reset = 1'b0;
        #1;
        check("rr_no_read", {29'h0, MemReadEn, Stall, Done}, 32'h0);
        @(posedge Clock); #1;
        check("rr_no_done", {30'h0, Done, MemReadEn}, 32'h0);

        run_op(LSU_SW, 32'h7C, 32'h0000CAFE);
        run_op(LSU_LW, 32'h7C, 32'h0);
        check("t6_lw", got_load, 32'h0000CAFE);
        poke(0, 32'hA5A5_0001);
        run_op(LSU_LW, 32'h80, 32'h0);
        check("t6_wrap", got_load, 32'hA5A5_0001);

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            lsu_op_e op;
            logic [31:0] a;
            op = lsu_op_e'(3'($urandom_range(0, 7)));
            a  = $urandom & 32'h0000_01FF;
            if (op == LSU_SW) a[1:0] = 2'b00;
            run_op(op, a, $urandom);
        end
        for (int i = 0; i < MEM_WORDS; i++) check("final_mem", mem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
